// File: rtl/alu_cc_writer.sv
`default_nettype none
// ============================================================================
// alu_cc_writer: classifies ALU results to one-hot N/Z/P, buffers and strobes
// them to the CC consumer; optional CC_LOAD_EN adds a load source for CC.
// Revision: 1.0 - initial release
// ============================================================================
module alu_cc_writer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clka,
  input  logic              reset_in,
  input  logic              res_valid_in,
  input  logic [DATA_W-1:0] res_data_in,
  input  logic              res_we_in,
  output logic              res_ready_out,
`ifdef CC_LOAD_EN
  input  logic              ld_valid_in,
  input  logic [DATA_W-1:0] ld_data_in,
  output logic              ld_ready_out,
`endif
  input  logic              cc_stall_in,
  output logic              n_alu_out,
  output logic              z_alu_out,
  output logic              p_alu_out,
  output logic              we_reg_out,
  output logic              busy_out
);

  localparam int         c_ADDR_W    = $clog2(DEPTH);
  localparam int         c_CNT_W     = c_ADDR_W + 1;
  localparam logic [2:0] c_CC_Z      = 3'b010;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_ADDR_W-1:0]   r_wr_ptr;
  logic [c_ADDR_W-1:0]   r_rd_ptr;
  logic [2:0]            r_mem [DEPTH];
  logic [2:0]            r_cc;

  logic                  w_full;
  logic                  w_res_xfer;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_W-1:0]     w_push_data;
  logic [2:0]            w_push_code;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic [c_CNT_W-1:0]    w_avail;
  logic [c_ADDR_W-1:0]   w_head_idx;
  logic [2:0]            w_head_code;

  // {N,Z,P}; exactly one bit set for any input
  function automatic logic [2:0] f_classify(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])
      return 3'b100;
    else if (d == '0)
      return 3'b010;
    else
      return 3'b001;
  endfunction

  assign w_full        = (r_count == c_DEPTH_CNT);
  assign res_ready_out = ~w_full;
  assign w_res_xfer    = res_valid_in & ~w_full;

`ifdef CC_LOAD_EN
  logic w_ld_xfer;
  assign ld_ready_out = ~w_full & ~res_valid_in;
  assign w_ld_xfer    = ld_valid_in & ld_ready_out;
  assign w_push       = (w_res_xfer & res_we_in) | w_ld_xfer;
  assign w_push_data  = w_res_xfer ? res_data_in : ld_data_in;
`else
  assign w_push       = w_res_xfer & res_we_in;
  assign w_push_data  = res_data_in;
`endif

  assign w_push_code = f_classify(w_push_data);
  assign w_pop       = (r_state == ST_ISSUE);
  assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

  // Head for the next strobe: oldest surviving entry, or the incoming one
  // when the buffer is about to be otherwise empty.
  assign w_avail     = r_count - c_CNT_W'(w_pop);
  assign w_head_idx  = r_rd_ptr + c_ADDR_W'(w_pop);
  assign w_head_code = (w_avail != '0) ? r_mem[w_head_idx] : w_push_code;

  always_ff @(posedge clka or negedge reset_in) begin
    if (!reset_in)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    we_reg_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_push)
          w_state_nxt = cc_stall_in ? ST_WAIT : ST_ISSUE;
      end
      ST_ISSUE: begin
        we_reg_out = 1'b1;
        if (w_count_nxt == '0)
          w_state_nxt = ST_IDLE;
        else if (cc_stall_in)
          w_state_nxt = ST_WAIT;
        else
          w_state_nxt = ST_ISSUE;
      end
      ST_WAIT: begin
        if (!cc_stall_in)
          w_state_nxt = ST_ISSUE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge reset_in) begin
    if (!reset_in) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
    end
  end

  always_ff @(posedge clka) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_push_code;
  end

  // Architectural CC: only updated when a strobe is about to start.
  always_ff @(posedge clka or negedge reset_in) begin
    if (!reset_in)
      r_cc <= c_CC_Z;
    else if (w_state_nxt == ST_ISSUE)
      r_cc <= w_head_code;
  end

  assign n_alu_out = r_cc[2];
  assign z_alu_out = r_cc[1];
  assign p_alu_out = r_cc[0];
  assign busy_out  = (r_state != ST_IDLE) | (r_count != '0);

  a_cc_onehot: assert property (@(posedge clka) disable iff (!reset_in)
    $onehot(r_cc));
  a_count_range: assert property (@(posedge clka) disable iff (!reset_in)
    r_count <= c_DEPTH_CNT);

endmodule
`default_nettype wire

// File: tb/tb_alu_cc_writer.sv
`default_nettype none
// ============================================================================
// tb_alu_cc_writer: vector table, reset corner sequence and random run
// against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_cc_writer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              clka = 1'b0;
  logic              reset_in;
  logic              res_valid_in;
  logic [DATA_W-1:0] res_data_in;
  logic              res_we_in;
  logic              res_ready_out;
  logic              cc_stall_in;
  logic              n_alu_out, z_alu_out, p_alu_out;
  logic              we_reg_out;
  logic              busy_out;
`ifdef CC_LOAD_EN
  logic              ld_ready_out;
`endif

  alu_cc_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clka         (clka),
    .reset_in     (reset_in),
    .res_valid_in (res_valid_in),
    .res_data_in  (res_data_in),
    .res_we_in    (res_we_in),
    .res_ready_out(res_ready_out),
`ifdef CC_LOAD_EN
    .ld_valid_in  (1'b0),
    .ld_data_in   ('0),
    .ld_ready_out (ld_ready_out),
`endif
    .cc_stall_in  (cc_stall_in),
    .n_alu_out    (n_alu_out),
    .z_alu_out    (z_alu_out),
    .p_alu_out    (p_alu_out),
    .we_reg_out   (we_reg_out),
    .busy_out     (busy_out)
  );

  always #5 clka = ~clka;

  int errors = 0;
  int checks = 0;

  // Reference model: pending codes in a queue, strobe flag, architectural CC
  logic [2:0] mq[$];
  bit         m_issue;
  logic [2:0] m_cc;

  function automatic logic [2:0] ref_code(input logic [DATA_W-1:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 0)         return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_issue = 1'b0;
    m_cc    = 3'b010;
  endtask

  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d,
                            input logic we, input logic st);
    bit acc;
    acc = v && (mq.size() < DEPTH);
    if (m_issue) void'(mq.pop_front());
    if (acc && we) mq.push_back(ref_code(d));
    m_issue = (mq.size() != 0) && !st;
    if (m_issue) m_cc = mq[0];
  endtask

  function automatic logic [5:0] model_vec();
    return {m_issue, m_cc, mq.size() < DEPTH, m_issue || (mq.size() != 0)};
  endfunction

  // {we, n, z, p, ready, busy}
  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {we_reg_out, n_alu_out, z_alu_out, p_alu_out, res_ready_out, busy_out};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got we,nzp,rdy,busy=%b required=%b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                       input logic we, input logic st);
    res_valid_in = v;
    res_data_in  = d;
    res_we_in    = we;
    cc_stall_in  = st;
    @(posedge clka);
    model_edge(v, d, we, st);
    #1;
  endtask

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              we;
    logic              st;
    logic [5:0]        exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 16'h8000, 1'b1, 1'b0, 6'b1_100_1_1};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'b0_100_1_0};
    vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 6'b1_010_1_1};
    vecs[3]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 6'b1_001_1_1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'b0_001_1_0};
    vecs[5]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 6'b0_001_1_0};
    vecs[6]  = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 6'b0_001_1_1};
    vecs[7]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 6'b0_001_0_1};
    vecs[8]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 6'b0_001_0_1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'b1_100_0_1};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'b1_001_1_1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'b0_001_1_0};

    reset_in     = 1'b0;
    res_valid_in = 1'b0;
    res_data_in  = '0;
    res_we_in    = 1'b0;
    cc_stall_in  = 1'b0;
    model_reset();
    repeat (3) @(posedge clka);
    #1;
    check("reset_held", 6'b0_010_1_0);
    reset_in = 1'b1;
    #1;
    check("reset_release", 6'b0_010_1_0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("idle_after_reset", 6'b0_010_1_0);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].we, vecs[i].st);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int i = 0; i < 400; i++) begin
      logic [DATA_W-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = 16'h8000 | 16'($urandom);
        2:       d = 16'h7FFF & 16'($urandom);
        default: d = 16'($urandom);
      endcase
      cycle($urandom_range(0, 1) == 1, d, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 3);
      check($sformatf("rand%0d", i), model_vec());
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check($sformatf("drain%0d", i), model_vec());
    end

    // Reset asserted while a strobe is in flight and two entries are pending
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
    cycle(1'b1, 16'h0001, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("pre_reset_issue", 6'b1_100_0_1);
    reset_in = 1'b0;
    #1;
    model_reset();
    check("reset_mid_issue", 6'b0_010_1_0);
    @(posedge clka);
    #1;
    reset_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check($sformatf("post_reset%0d", i), 6'b0_010_1_0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
